// File: rtl/bomb_pkg.sv
// Shared state/direction types, arena geometry and the pixel-to-tile snap helpers.
package bomb_pkg;

  typedef enum logic [1:0] {IDLE, FUSE, CLEAR, EXPLODE} state_e;
  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_SCAN, SEQ_REQ} seq_state_e;

  localparam int UP_LEFT_X   = 48;
  localparam int UP_LEFT_Y   = 32;
  localparam int HB_OFFSET   = 9;
  localparam int TILE_COLS   = 33;
  localparam int TILE_ROWS   = 26;
  localparam int SPRITE_HALF = 8;

  // Hitbox centre relative to the arena origin: x_b-40, y_b-15.
  localparam int SNAP_X = UP_LEFT_X - SPRITE_HALF;
  localparam int SNAP_Y = UP_LEFT_Y - HB_OFFSET - SPRITE_HALF;

  function automatic logic [5:0] snap_x(input logic [9:0] x);
    return 6'((x - 10'(SNAP_X)) >> 4);
  endfunction

  function automatic logic [4:0] snap_y(input logic [9:0] y);
    return 5'((y - 10'(SNAP_Y)) >> 4);
  endfunction

endpackage

// File: rtl/bomb_if.sv
// Player/motion inputs, display outputs and the block-map clear handshake of one bomb.
interface bomb_if;
  logic       place;
  logic [9:0] x_b;
  logic [9:0] y_b;
  logic       gameover;
  logic       bomb_on;
  logic       exp_on;
  logic [5:0] tile_x;
  logic [4:0] tile_y;
  logic       clr_req;
  logic [5:0] clr_x;
  logic [4:0] clr_y;
  logic       clr_ack;
  logic       done;

  modport master (
    input  place, x_b, y_b, gameover, clr_ack,
    output bomb_on, exp_on, tile_x, tile_y, clr_req, clr_x, clr_y, done
  );

  modport slave (
    output place, x_b, y_b, gameover, clr_ack,
    input  bomb_on, exp_on, tile_x, tile_y, clr_req, clr_x, clr_y, done
  );
endinterface

// File: rtl/bomb_clear_seq.sv
// Walks up/right/down/left around the bomb tile, requesting a clear for each in-range non-pillar tile.
// clr_req is held until clr_ack; abort only takes effect when no request is outstanding.
module bomb_clear_seq
  import bomb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [5:0] tile_x,
  input  logic [4:0] tile_y,
  input  logic       clr_ack,
  output logic       clr_req,
  output logic [5:0] clr_x,
  output logic [4:0] clr_y,
  output logic       finish,
  output logic       aborted
);

  seq_state_e state, state_nx;
  dir_e       dir, dir_nx;
  logic [6:0] nb_x;
  logic [5:0] nb_y;
  logic       nb_ok;

  // One extra bit so that stepping off column/row 0 wraps to a value that fails the range test.
  always_comb begin
    nb_x = {1'b0, tile_x};
    nb_y = {1'b0, tile_y};
    case (dir)
      DIR_UP:    nb_y = {1'b0, tile_y} - 6'd1;
      DIR_RIGHT: nb_x = {1'b0, tile_x} + 7'd1;
      DIR_DOWN:  nb_y = {1'b0, tile_y} + 6'd1;
      DIR_LEFT:  nb_x = {1'b0, tile_x} - 7'd1;
    endcase
    nb_ok = (nb_x < 7'(TILE_COLS)) && (nb_y < 6'(TILE_ROWS)) && !(nb_x[0] && nb_y[0]);
  end

  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    finish   = 1'b0;
    aborted  = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_nx = SEQ_SCAN;
          dir_nx   = DIR_UP;
        end
      end
      SEQ_SCAN: begin
        if (abort) begin
          state_nx = SEQ_IDLE;
          aborted  = 1'b1;
        end else if (nb_ok) begin
          state_nx = SEQ_REQ;
        end else if (dir == DIR_LEFT) begin
          state_nx = SEQ_IDLE;
          finish   = 1'b1;
        end else begin
          dir_nx = dir_e'(dir + 2'd1);
        end
      end
      SEQ_REQ: begin
        if (clr_ack) begin
          if (abort) begin
            state_nx = SEQ_IDLE;
            aborted  = 1'b1;
          end else if (dir == DIR_LEFT) begin
            state_nx = SEQ_IDLE;
            finish   = 1'b1;
          end else begin
            state_nx = SEQ_SCAN;
            dir_nx   = dir_e'(dir + 2'd1);
          end
        end
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEQ_IDLE;
      dir     <= DIR_UP;
      clr_req <= 1'b0;
      clr_x   <= '0;
      clr_y   <= '0;
    end else begin
      state   <= state_nx;
      dir     <= dir_nx;
      clr_req <= (state_nx == SEQ_REQ);
      if (state == SEQ_SCAN && state_nx == SEQ_REQ) begin
        clr_x <= nb_x[5:0];
        clr_y <= nb_y[4:0];
      end
    end
  end

endmodule

// File: rtl/bomb_controller.sv
// Single-bomb lifecycle: place, fuse, neighbour clear, explosion, back to idle; outputs registered.
// Define BOMB_REMOTE_EN to let a fresh place press during the fuse detonate the bomb early.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int FUSE_CYCLES = 200_000_000,
  parameter int EXP_CYCLES  = 50_000_000,
  parameter int CNT_W       = 28
) (
  input  logic   clk,
  input  logic   reset,
  bomb_if.master bus
);

  state_e           state, state_nx;
  logic [CNT_W-1:0] timer;
  logic             place_q;
  logic             place_rise;
  logic             remote_fire;
  logic             fuse_end;
  logic             exp_end;
  logic             seq_start;
  logic             seq_finish;
  logic             seq_aborted;

  assign place_rise = bus.place & ~place_q;
  assign fuse_end   = (timer == CNT_W'(FUSE_CYCLES - 1));
  assign exp_end    = (timer == CNT_W'(EXP_CYCLES - 1));

`ifdef BOMB_REMOTE_EN
  assign remote_fire = place_rise;
`else
  assign remote_fire = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (place_rise && !bus.gameover) state_nx = FUSE;
      FUSE: begin
        if (bus.gameover)                state_nx = IDLE;
        else if (fuse_end || remote_fire) state_nx = CLEAR;
      end
      CLEAR: begin
        if (seq_aborted)     state_nx = IDLE;
        else if (seq_finish) state_nx = EXPLODE;
      end
      EXPLODE: if (exp_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    seq_start = (state != CLEAR) && (state_nx == CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      place_q     <= 1'b0;
      bus.bomb_on <= 1'b0;
      bus.exp_on  <= 1'b0;
      bus.done    <= 1'b0;
      bus.tile_x  <= '0;
      bus.tile_y  <= '0;
    end else begin
      state   <= state_nx;
      place_q <= bus.place;
      // Timer restarts on every state change so each timed state starts its count at 0.
      if (state_nx != state || !(state == FUSE || state == EXPLODE)) timer <= '0;
      else                                                           timer <= timer + 1'b1;
      bus.bomb_on <= (state_nx == FUSE);
      bus.exp_on  <= (state_nx == EXPLODE);
      bus.done    <= (state == EXPLODE) && (state_nx == IDLE);
      if (state == IDLE && state_nx == FUSE) begin
        bus.tile_x <= snap_x(bus.x_b);
        bus.tile_y <= snap_y(bus.y_b);
      end
    end
  end

  bomb_clear_seq u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (seq_start),
    .abort   (bus.gameover),
    .tile_x  (bus.tile_x),
    .tile_y  (bus.tile_y),
    .clr_ack (bus.clr_ack),
    .clr_req (bus.clr_req),
    .clr_x   (bus.clr_x),
    .clr_y   (bus.clr_y),
    .finish  (seq_finish),
    .aborted (seq_aborted)
  );

endmodule

// File: tb/tb_bomb_controller.sv
// Directed and randomized bomb lifecycles checked against a tile/neighbour model of the arena rules.
module tb_bomb_controller;

  localparam int FUSE = 10;
  localparam int EXP  = 4;
`ifdef BOMB_REMOTE_EN
  localparam bit REMOTE = 1'b1;
`else
  localparam bit REMOTE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  bomb_if bus ();

  bomb_controller #(.FUSE_CYCLES(FUSE), .EXP_CYCLES(EXP), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int m_tx(input int x);
    return (((x - 40 + 1024) % 1024) / 16) % 64;
  endfunction

  function automatic int m_ty(input int y);
    return (((y - 15 + 1024) % 1024) / 16) % 32;
  endfunction

  // Expected clear requests, encoded x*64+y, in up/right/down/left order.
  task automatic m_neighbours(input int tx, input int ty, output int q[$]);
    int dx[4] = '{0, 1, 0, -1};
    int dy[4] = '{-1, 0, 1, 0};
    q = {};
    for (int d = 0; d < 4; d++) begin
      int nx = tx + dx[d];
      int ny = ty + dy[d];
      if (nx >= 0 && nx < 33 && ny >= 0 && ny < 26 && !((nx % 2 == 1) && (ny % 2 == 1)))
        q.push_back(nx * 64 + ny);
    end
  endtask

  // One full bomb from the place press to the cycle after done; entered and left at a negedge.
  task automatic bomb_cycle(input int x, input int y, input int dly, input bit hold,
                            input bit noise, input int press_at, output int first_req);
    int n, g, k, cx, cy, exp_fuse;
    int got[$];
    int expq[$];
    m_neighbours(m_tx(x), m_ty(y), expq);
    exp_fuse = (press_at >= 0 && REMOTE) ? press_at + 1 : FUSE;
    bus.x_b   = 10'(x);
    bus.y_b   = 10'(y);
    bus.place = 1'b1;
    @(negedge clk);
    bus.place = hold;
    check("tile_x", bus.tile_x, m_tx(x));
    check("tile_y", bus.tile_y, m_ty(y));
    n = 0;
    while (bus.bomb_on && n < 100) begin
      n++;
      @(negedge clk);
      bus.place = hold || (n == press_at);
    end
    check("fuse_len", n, exp_fuse);
    g = 0;
    k = 0;
    cx = 0;
    cy = 0;
    first_req = -1;
    while (!bus.exp_on && g < 300) begin
      if (bus.clr_req) begin
        if (k == 0) begin
          cx = int'(bus.clr_x);
          cy = int'(bus.clr_y);
          got.push_back(cx * 64 + cy);
          if (first_req < 0) first_req = g;
        end else begin
          check("clr_x_stable", bus.clr_x, cx);
          check("clr_y_stable", bus.clr_y, cy);
        end
        k++;
        bus.clr_ack = (k > dly);
      end else begin
        if (k != 0) check("req_len", k, dly + 1);
        k = 0;
        bus.clr_ack = noise;
      end
      g++;
      @(negedge clk);
    end
    bus.clr_ack = 1'b0;
    if (k != 0) check("req_len", k, dly + 1);
    check("clear_reaches_explode", bus.exp_on, 1);
    check("req_count", got.size(), expq.size());
    foreach (expq[i]) if (i < got.size()) check("req_tile", got[i], expq[i]);
    n = 0;
    while (bus.exp_on && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("exp_len", n, EXP);
    check("done_pulse", bus.done, 1);
    check("idle_bomb_off", bus.bomb_on, 0);
    @(negedge clk);
    check("done_once", bus.done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, fr, x, y, dly;
    bit nz, seen;
    reset        = 1'b0;
    bus.place    = 1'b0;
    bus.x_b      = '0;
    bus.y_b      = '0;
    bus.gameover = 1'b0;
    bus.clr_ack  = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bomb_on", bus.bomb_on, 0);
    check("rst_exp_on", bus.exp_on, 0);
    check("rst_tile_x", bus.tile_x, 0);
    check("rst_tile_y", bus.tile_y, 0);
    check("rst_clr_req", bus.clr_req, 0);
    check("rst_clr_x", bus.clr_x, 0);
    check("rst_clr_y", bus.clr_y, 0);
    check("rst_done", bus.done, 0);
    reset = 1'b0;
    @(negedge clk);

    // Tile (1,0): up off-arena, right (2,0), down (1,1) pillar, left (0,0).
    bomb_cycle(64, 23, 0, 1'b0, 1'b0, -1, fr);
    check("first_tile_x_const", bus.tile_x, 1);
    repeat (2) @(negedge clk);

    // Held button arms exactly one bomb.
    bomb_cycle(72, 47, 0, 1'b1, 1'b0, -1, fr);
    seen = 1'b0;
    repeat (80) begin
      seen |= bus.bomb_on;
      @(negedge clk);
    end
    check("held_no_rearm", seen, 0);
    bus.place = 1'b0;
    repeat (2) @(negedge clk);

    // Slow block map with stray acks while no request is up.
    bomb_cycle(72, 47, 5, 1'b0, 1'b1, -1, fr);
    repeat (2) @(negedge clk);
    // Far corner tile (32,25): only up survives.
    bomb_cycle(552, 415, 2, 1'b0, 1'b0, -1, fr);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      x   = int'($urandom_range(0, 1023));
      y   = int'($urandom_range(0, 1023));
      dly = int'($urandom_range(0, 5));
      nz  = 1'($urandom_range(0, 1));
      bomb_cycle(x, y, dly, 1'b0, nz, -1, fr);
      repeat (2) @(negedge clk);
    end

    // Game over during the fuse.
    bus.x_b   = 10'd72;
    bus.y_b   = 10'd47;
    bus.place = 1'b1;
    @(negedge clk);
    bus.place = 1'b0;
    check("go_fuse_started", bus.bomb_on, 1);
    repeat (3) @(negedge clk);
    bus.gameover = 1'b1;
    @(negedge clk);
    check("go_bomb_off", bus.bomb_on, 0);
    bus.gameover = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      seen |= bus.bomb_on | bus.exp_on | bus.clr_req | bus.done;
      @(negedge clk);
    end
    check("go_quiet", seen, 0);

    // Press while game over is high does nothing.
    bus.gameover = 1'b1;
    bus.place    = 1'b1;
    @(negedge clk);
    bus.place = 1'b0;
    check("go_idle_no_fuse", bus.bomb_on, 0);
    @(negedge clk);
    bus.gameover = 1'b0;
    repeat (2) @(negedge clk);

    // Reset with a request outstanding, then a fresh bomb.
    bus.place = 1'b1;
    @(negedge clk);
    bus.place = 1'b0;
    n = 0;
    while (!bus.clr_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rst_mid_req_seen", bus.clr_req, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_clr_req", bus.clr_req, 0);
    check("rst_mid_bomb_on", bus.bomb_on, 0);
    check("rst_mid_exp_on", bus.exp_on, 0);
    check("rst_mid_tile_x", bus.tile_x, 0);
    check("rst_mid_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bomb_cycle(64, 23, 1, 1'b0, 1'b0, -1, fr);
    repeat (2) @(negedge clk);

    // Second press at fuse cycle 4: early detonation only with the remote option.
    bomb_cycle(72, 47, 0, 1'b0, 1'b0, 4, fr);
    check("remote_req_within_2", (fr >= 0 && fr <= 1), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
